// File: rtl/serv_dbg_pkg.sv
// ---------------------------------------------------------------------------
// serv_dbg_pkg
//
// Shared definitions for the SERV debug register-file mirror:
//   - beat count / beat-counter width derivation from the RF write width
//   - assembly state encoding (IDLE / ASM)
//   - mirrored register counts for the plain and CSR-enabled builds
//
// Related configuration macro: SERV_DBG_RF_MIRROR_CSR_EN (selects NREGS_CSR
// in the top level).
// ---------------------------------------------------------------------------
package serv_dbg_pkg;

    // Register counts for the two build flavours.
    localparam int NREGS_BASE = 32;
    localparam int NREGS_CSR  = 36;

    // Number of RF_WIDTH-bit beats that make up one 32-bit register write.
    function automatic int beats_of(input int rf_width);
        return 32 / rf_width;
    endfunction

    // Beat counter width; a single-beat configuration still gets one bit
    // so that the counter never becomes a zero-width vector.
    function automatic int cnt_w_of(input int rf_width);
        int beats;
        beats = 32 / rf_width;
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ASM  = 1'b1
    } asm_state_e;

endpackage

// File: rtl/serv_dbg_rf_assembler.sv
// ---------------------------------------------------------------------------
// serv_dbg_rf_assembler
//
// Rebuilds 32-bit register writes from the RF RAM write taps, LSB chunk
// first, and emits a single-cycle commit with the destination index and the
// complete word. The last beat is bypassed straight from i_rf_wdata so the
// commit happens in the same cycle the last beat is presented.
//
// Ports:
//   clk            in   clock, rising edge
//   i_rst_n        in   synchronous active-low reset
//   i_rf_wreq      in   start (or restart) of a write sequence
//   i_rf_wreg      in   6-bit destination index, stable during the sequence
//   i_rf_w1wren    in   write port 1 enable, qualifies beats
//   i_rf_we        in   beat strobe
//   i_rf_wdata     in   RF_WIDTH-bit beat data
//   o_commit       out  one-cycle pulse: complete word available
//   o_commit_idx   out  destination index of the committed word
//   o_commit_word  out  assembled 32-bit word
//   o_busy         out  high while a sequence is partially assembled
// ---------------------------------------------------------------------------
module serv_dbg_rf_assembler
    import serv_dbg_pkg::*;
#(
    parameter int RF_WIDTH = 8
) (
    input  logic                clk,
    input  logic                i_rst_n,
    input  logic                i_rf_wreq,
    input  logic [5:0]          i_rf_wreg,
    input  logic                i_rf_w1wren,
    input  logic                i_rf_we,
    input  logic [RF_WIDTH-1:0] i_rf_wdata,
    output logic                o_commit,
    output logic [5:0]          o_commit_idx,
    output logic [31:0]         o_commit_word,
    output logic                o_busy
);

    localparam int BEATS = beats_of(RF_WIDTH);
    localparam int CNT_W = cnt_w_of(RF_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    asm_state_e       state;
    asm_state_e       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [31:0]      asm_word;

    logic             beat_ok;
    logic [CNT_W-1:0] beat_idx;
    logic             last_beat;
    logic [31:0]      word_next;

    // A beat coinciding with i_rf_wreq belongs to the new sequence, so it is
    // accepted even from IDLE and always lands in slot 0.
    always_comb begin
        beat_ok   = i_rf_we & i_rf_w1wren & (i_rf_wreq | (state == ST_ASM));
        beat_idx  = i_rf_wreq ? '0 : cnt;
        last_beat = beat_ok & (beat_idx == LAST_BEAT);
        word_next = asm_word;
        word_next[int'(beat_idx) * RF_WIDTH +: RF_WIDTH] = i_rf_wdata;
    end

    // Next-state and counter. A completed word always returns to IDLE; a
    // fresh request otherwise restarts assembly and drops any partial word.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (last_beat) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
        end else if (i_rf_wreq) begin
            state_next = ST_ASM;
            cnt_next   = beat_ok ? CNT_W'(1) : '0;
        end else if (beat_ok) begin
            cnt_next   = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Data register carries no reset: stale upper chunks are always
    // overwritten before a word can be committed.
    always_ff @(posedge clk) begin
        if (beat_ok) begin
            asm_word <= word_next;
        end
    end

    assign o_commit      = last_beat;
    assign o_commit_idx  = i_rf_wreg;
    assign o_commit_word = word_next;
    assign o_busy        = (state == ST_ASM);

endmodule

// File: rtl/serv_dbg_rf_mirror.sv
// ---------------------------------------------------------------------------
// serv_dbg_rf_mirror
//
// Debug-side shadow of the SERV register file. Register writes are rebuilt
// from the RF write taps by serv_dbg_rf_assembler and committed into a
// shadow array; the debugger reads that array through a req/ack port with a
// fixed one-cycle latency, never touching the core's RF RAM.
//
// Entries are qualified by per-entry valid bits that reset to 0, so every
// entry reads 0 after reset without clearing the array itself. Index 0 is
// never committed and always reads 0.
//
// Configuration macro: SERV_DBG_RF_MIRROR_CSR_EN
//   defined   -> NREGS = 36 (indices 32..35 mirror RF-resident CSR slots),
//                i_dbg_regno is 6 bits
//   undefined -> NREGS = 32, indices 32..35 are dropped, i_dbg_regno is
//                5 bits
//
// Ports:
//   clk          in   clock, rising edge
//   i_rst_n      in   synchronous active-low reset
//   i_rf_wreq    in   start of a register write sequence
//   i_rf_wreg    in   6-bit destination register index
//   i_rf_w1wren  in   write port 1 enable
//   i_rf_we      in   beat strobe
//   i_rf_wdata   in   RF_WIDTH-bit beat data, LSB chunk first
//   i_dbg_req    in   read request pulse
//   i_dbg_regno  in   register to read (5 or 6 bits)
//   o_dbg_ack    out  read data valid, one-cycle pulse
//   o_dbg_rdata  out  read data, held until the next ack
//   o_busy       out  write sequence partially assembled
// ---------------------------------------------------------------------------
module serv_dbg_rf_mirror
    import serv_dbg_pkg::*;
#(
    parameter int RF_WIDTH = 8,
`ifdef SERV_DBG_RF_MIRROR_CSR_EN
    parameter int NREGS    = NREGS_CSR
`else
    parameter int NREGS    = NREGS_BASE
`endif
) (
    input  logic                clk,
    input  logic                i_rst_n,
    input  logic                i_rf_wreq,
    input  logic [5:0]          i_rf_wreg,
    input  logic                i_rf_w1wren,
    input  logic                i_rf_we,
    input  logic [RF_WIDTH-1:0] i_rf_wdata,
    input  logic                i_dbg_req,
`ifdef SERV_DBG_RF_MIRROR_CSR_EN
    input  logic [5:0]          i_dbg_regno,
`else
    input  logic [4:0]          i_dbg_regno,
`endif
    output logic                o_dbg_ack,
    output logic [31:0]         o_dbg_rdata,
    output logic                o_busy
);

    localparam int IDX_W = $clog2(NREGS);

    logic             commit;
    logic [5:0]       commit_idx;
    logic [31:0]      commit_word;
    logic             commit_ok;
    logic [IDX_W-1:0] commit_slot;

    logic [5:0]       regno_p0;
    logic [IDX_W-1:0] rd_slot_p0;
    logic             rd_in_range_p0;
    logic             rd_fwd_p0;
    logic [31:0]      rd_word_p0;

    logic [31:0]      shadow [NREGS];
    logic [NREGS-1:0] valid;

    serv_dbg_rf_assembler #(
        .RF_WIDTH (RF_WIDTH)
    ) u_asm (
        .clk           (clk),
        .i_rst_n       (i_rst_n),
        .i_rf_wreq     (i_rf_wreq),
        .i_rf_wreg     (i_rf_wreg),
        .i_rf_w1wren   (i_rf_w1wren),
        .i_rf_we       (i_rf_we),
        .i_rf_wdata    (i_rf_wdata),
        .o_commit      (commit),
        .o_commit_idx  (commit_idx),
        .o_commit_word (commit_word),
        .o_busy        (o_busy)
    );

    // x0 is hard-wired to zero and indices beyond the mirrored range are
    // simply dropped.
    always_comb begin
        commit_ok   = commit & (commit_idx != 6'd0) & (commit_idx < 6'(NREGS));
        commit_slot = commit_idx[IDX_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (commit_ok) begin
            shadow[commit_slot] <= commit_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            valid <= '0;
        end else if (commit_ok) begin
            valid[commit_slot] <= 1'b1;
        end
    end

    // ---- request stage: select data, forwarding a same-cycle commit ----
    always_comb begin
        regno_p0       = 6'(i_dbg_regno);
        rd_slot_p0     = regno_p0[IDX_W-1:0];
        rd_in_range_p0 = (regno_p0 != 6'd0) & (regno_p0 < 6'(NREGS));
        rd_fwd_p0      = commit_ok & (commit_idx == regno_p0);
        rd_word_p0     = '0;
        if (rd_in_range_p0) begin
            if (rd_fwd_p0) begin
                rd_word_p0 = commit_word;
            end else if (valid[rd_slot_p0]) begin
                rd_word_p0 = shadow[rd_slot_p0];
            end
        end
    end

    // ---- response stage: ack one cycle after the request ----
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            o_dbg_ack   <= 1'b0;
            o_dbg_rdata <= '0;
        end else begin
            o_dbg_ack <= i_dbg_req;
            if (i_dbg_req) begin
                o_dbg_rdata <= rd_word_p0;
            end
        end
    end

endmodule

// File: doc/serv_dbg_rf_mirror.md
# serv_dbg_rf_mirror

Debug-side shadow of the SERV general-purpose register file. Sits directly downstream of the RF top's debug write taps (register index, write strobe, RF_WIDTH-bit write data). It reassembles each register write from its RF_WIDTH-bit beats and commits the 32-bit result into a shadow array. The debug module reads the array over a req/ack port without stalling or touching the core's RF RAM.

## Interface
Parameters:
- RF_WIDTH, 8: beat width of the RF RAM write path; legal values 2, 4, 8, 16, 32; BEATS = 32/RF_WIDTH.
- NREGS, 32: mirrored register count. Becomes 36 under SERV_DBG_RF_MIRROR_CSR_EN.

Ports:
- clk  in  1  sole clock, rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_rf_wreq  in  1  core write-request pulse; marks the start of a register write sequence.
- i_rf_wreg  in  6  destination register index, stable for the whole sequence.
- i_rf_w1wren  in  1  write port 1 enable; beats are captured only when high.
- i_rf_we  in  1  beat strobe; one RF_WIDTH chunk is valid this cycle.
- i_rf_wdata  in  RF_WIDTH  beat data, LSB chunk first.
- i_dbg_req  in  1  debugger read request, single-cycle pulse.
- i_dbg_regno  in  5 (6 with CSR_EN)  register to read.
- o_dbg_ack  out  1  read data valid, one-cycle pulse.
- o_dbg_rdata  out  32  read data; holds its value until the next ack.
- o_busy  out  1  high while a write sequence is partially assembled.

## Operation
- Assembly state machine, two states:
  - IDLE to ASM on i_rf_wreq.
  - ASM back to IDLE after beat BEATS-1 is captured, or on a new i_rf_wreq (restart).
- Beat counter:
  - Width log2(BEATS); cleared on i_rf_wreq.
  - Increments on each qualified beat (i_rf_we & i_rf_w1wren while in ASM). It does not wrap mid-sequence.
- Assembly register:
  - Beat k is written to bits [k*RF_WIDTH +: RF_WIDTH].
  - On the last beat the word is committed to shadow[i_rf_wreg] the same cycle. The last beat is taken directly from i_rf_wdata, not from the register.
- Index filtering:
  - Writes with i_rf_wreg = 0 are assembled but never committed; shadow[0] always reads 0.
  - Indices >= NREGS are discarded.
- Beats outside ASM are ignored. A sequence interrupted by i_rf_wreq is discarded and its register is not modified.
- Read port:
  - i_dbg_req samples i_dbg_regno. One cycle later o_dbg_ack=1 and o_dbg_rdata=shadow[regno].
  - A commit to the same register in the request cycle is forwarded, so the read returns the new value.
  - Back-to-back requests are allowed, one per cycle.
  - An out-of-range regno returns 0 with ack.
- o_busy = (state == ASM).

## Timing
- Reset, synchronous, while i_rst_n=0 at a rising edge:
  - state=IDLE, counter=0, o_dbg_ack=0, o_dbg_rdata=0, o_busy=0.
  - All shadow entries read 0 after reset; this uses a per-entry valid bit cleared on reset, not a RAM clear.
- Reset mid-sequence discards the partial word. Reset in the request cycle suppresses the ack.
- Write latency: the shadow is updated at the edge ending the last beat. It is visible to a request issued in that same cycle through forwarding.
- Read latency: exactly 1 cycle from request to ack, with no back-pressure.
- i_rf_wreq and the first beat may coincide. The beat then counts as beat 0 of the new sequence.

## Configuration
- SERV_DBG_RF_MIRROR_CSR_EN defined:
  - NREGS=36; indices 32..35 mirror the four RF-resident CSR slots.
  - i_dbg_regno is 6 bits.
- Undefined:
  - NREGS=32; indices 32..35 are dropped.
  - i_dbg_regno is 5 bits, and CSR storage is not synthesized.

## Structure
- Shared package serv_dbg_pkg holds:
  - The BEATS and counter-width derivation.
  - The IDLE/ASM state encoding.
  - NREGS constants for the two configurations.
- One sub-module: serv_dbg_rf_assembler. It contains the state machine, beat counter and assembly register, and outputs a commit pulse, index and 32-bit word.
- The top level holds the shadow array, valid bits and read/forward logic.

## Test plan
- Reset, then read x5 -> ack after 1 cycle, rdata=0x00000000, o_busy=0.
- wreq with wreg=5, then 4 beats 0xEF,0xBE,0xAD,0xDE (RF_WIDTH=8) -> o_busy high for the beats. A read of x5 returns 0xDEADBEEF.
- A write to x0 with 0xFFFFFFFF -> a read of x0 returns 0.
- wreq wreg=7, 2 beats, then a new wreq wreg=8 with 4 beats of 0x11 -> x7 is unchanged (0) and x8 = 0x11111111.
- Request x9 in the same cycle as the last beat of a write of 0x12345678 to x9 -> ack the next cycle with 0x12345678.
- i_rst_n low after 3 of 4 beats to x3, then finish the beats -> x3 reads 0 and o_busy=0. With CSR_EN, a write to index 33 of 0xA5A5A5A5 reads back from regno 33.
